fp_to_int_converter: RTL and testbench
======================================

# fp_to_int_converter

Multi-cycle FP-to-integer conversion unit for the FPU; the inverse direction of the FP add/sub datapath, which produces IEEE-754 encodings from internal sign/exponent/mantissa. It accepts a single- or double-precision operand over a valid/ready handshake. It aligns the significand iteratively, 8 bits per cycle, then rounds, range-checks and saturates into a signed/unsigned 32- or 64-bit integer with invalid/inexact flags.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  unit can accept; high only in IDLE
- operand  in  64  FP input; single precision uses operand[31:0]
- is_double_precision  in  1  1 = binary64, 0 = binary32
- is_signed  in  1  1 = signed target, 0 = unsigned
- is_64bit_result  in  1  1 = 64-bit target, 0 = 32-bit
- rounding_mode  in  3  000 RNE, 001 RTZ, 010 RDN (−inf), 011 RUP (+inf), 100 RMM; others behave as RTZ
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  64  integer result; 32-bit results sign-extended from bit 31, signed or unsigned
- flag_invalid  out  1  NaN, infinity or out-of-range
- flag_inexact  out  1  rounding discarded nonzero bits; never set together with invalid

## Operation
- States: IDLE, SHIFT, ROUND, DONE.
- Accept in IDLE on in_valid, which is also the handshake edge. Capture the mode bits and classify the operand. e = unbiased exponent, with denormals using e = 1−bias.
- NaN or infinity: go to ROUND with the special flag set.
- Zero: magnitude 0, guard 0, sticky 0.
- e < 0: magnitude 0. For e = −1, guard = 1 and sticky = |fraction. For e < −1, guard = 0 and sticky = 1.
- e ≥ 64: overflow; go to ROUND with the special flag set.
- Otherwise:
  - Load the 116-bit accumulator as {int[63:0]=1, frac[51:0]}. Single-precision fraction is left-aligned into frac.
  - Set remaining = e and go to SHIFT when e > 0, else go to ROUND.
- SHIFT: each cycle, shift the accumulator left by k = min(remaining, 8) and do remaining −= k. Go to ROUND when remaining reaches 0.
- ROUND:
  - guard = frac[51], sticky = |frac[50:0].
  - round_up:
    - RNE: g&(s|int[0])
    - RMM: g
    - RUP: (g|s)&!sign
    - RDN: (g|s)&sign
    - RTZ: 0
  - mag = int + round_up, computed at 65 bits.
- Range check on mag:
  - signed N-bit: positive requires mag ≤ 2^(N−1)−1; negative requires mag ≤ 2^(N−1).
  - unsigned: negative with mag ≠ 0 is invalid; positive requires mag ≤ 2^N−1.
- Invalid results:
  - NaN or positive overflow: signed max, or all-ones for unsigned.
  - Negative overflow: signed min, or 0 for unsigned.
- Valid results: two's complement when sign is set. flag_inexact = g|s.
- Negative values that round to 0 on an unsigned target give result 0. This is not invalid; inexact follows g|s.
- ROUND registers result and flags, then goes to DONE.
- DONE: out_valid = 1, outputs held stable. On out_ready, go to IDLE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, both flags 0.
- n = ceil(e/8) for 0 < e ≤ 63, else n = 0.
- out_valid rises at the (n+2)th rising edge, counting the accept edge as the first. The maximum is 10 edges, for e = 63.
- No overlap between operations: in_ready is 0 from the accept edge until the DONE→IDLE edge.
- in_valid is ignored outside IDLE.
- Outputs are held unchanged while out_valid & !out_ready.
- rst_n asserted in any state aborts the operation immediately: no output and no flags. The unit is in IDLE when rst_n deasserts.

## Structure
- Shared fpu_pkg holds:
  - rounding-mode constants (RNE/RTZ/RDN/RUP/RMM)
  - bias constants 127/1023
  - the conversion state enum
- One combinational sub-module, fp_int_round_sat. Inputs: int, g, s, sign, special flags, mode bits. Outputs: result, flag_invalid, flag_inexact. The FSM, accumulator and handshake stay in the top level.

## Test plan
- 0x400C000000000000 (3.5), RNE, signed 64 → 4, inexact=1. out_valid at edge 3 (n=1).
- 0x4004000000000000 (2.5), signed 64:
  - RNE → 2 and RTZ → 2.
  - RUP → 3 and RMM → 3.
  - inexact=1 in all four modes.
- 0xBFC00000 (−1.5 single), unsigned 32, RTZ → 0, invalid=1. 0xBE800000 (−0.25) under the same settings → 0, inexact=1, invalid=0.
- 0x43E0000000000000 (2^63), signed 64 → 0x7FFFFFFFFFFFFFFF, invalid=1. 0xC3E0000000000000 (−2^63) → 0x8000000000000000, no flags, out_valid at edge 10.
- 0x7FF8000000000000 (NaN), signed 32 → 0x000000007FFFFFFF, invalid=1. 0xFFF0000000000000 (−inf), unsigned 64 → 0, invalid=1.
- Hold out_ready=0 for 5 cycles after out_valid → result stable, in_ready=0. Assert rst_n low mid-SHIFT → out_valid stays 0, in_ready=1, next operand converts correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes,
// exponent biases and FP->int conversion states.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [12:0] BIAS_SP = 13'd127;
  localparam logic [12:0] BIAS_DP = 13'd1023;

  typedef enum logic [1:0] {
    CVT_IDLE,
    CVT_SHIFT,
    CVT_ROUND,
    CVT_DONE
  } cvt_state_e;

endpackage

// File: rtl/fp_to_int_converter_if.sv
// Operand/result handshake bundle for the
// FP->int converter.
interface fp_to_int_converter_if;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] operand;
  logic        is_double_precision;
  logic        is_signed;
  logic        is_64bit_result;
  logic [2:0]  rounding_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        flag_invalid;
  logic        flag_inexact;

  modport master (
    output in_valid,
    output operand,
    output is_double_precision,
    output is_signed,
    output is_64bit_result,
    output rounding_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  flag_invalid,
    input  flag_inexact
  );

  modport slave (
    input  in_valid,
    input  operand,
    input  is_double_precision,
    input  is_signed,
    input  is_64bit_result,
    input  rounding_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output flag_invalid,
    output flag_inexact
  );

endinterface

// File: rtl/fp_to_int_converter_round_sat.sv
// Rounding, range check and saturation of an
// aligned magnitude into a 32/64-bit integer.
module fp_int_round_sat
  import fpu_pkg::*;
(
  input  logic [63:0] int_part,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
  input  logic        is_nan,
  input  logic        is_ovf,
  input  logic        is_signed,
  input  logic        is_64bit,
  input  logic [2:0]  rounding_mode,
  output logic [63:0] result,
  output logic        flag_invalid,
  output logic        flag_inexact
);

  logic        round_up;
  logic [64:0] mag;
  logic [64:0] pos_lim;
  logic [64:0] neg_lim;
  logic [63:0] sat_pos;
  logic [63:0] sat_neg;
  logic [63:0] twos;
  logic        overflow;

  // Round-increment decision per rounding mode
  always_comb begin
    round_up = 1'b0;
    unique case (1'b1)
      rounding_mode == RM_RNE:
        round_up = guard & (sticky | int_part[0]);
      rounding_mode == RM_RMM:
        round_up = guard;
      rounding_mode == RM_RUP:
        round_up = (guard | sticky) & ~sign;
      rounding_mode == RM_RDN:
        round_up = (guard | sticky) & sign;
      default:
        round_up = 1'b0;
    endcase
  end

  // Limits, saturation and final result select
  always_comb begin
    mag = {1'b0, int_part} + {64'd0, round_up};
    if (is_64bit) begin
      pos_lim = is_signed ? {2'b00, {63{1'b1}}}
                          : {1'b0, {64{1'b1}}};
      neg_lim = is_signed ? {2'b01, 63'd0} : 65'd0;
      sat_pos = is_signed ? {1'b0, {63{1'b1}}}
                          : {64{1'b1}};
      sat_neg = is_signed ? {1'b1, 63'd0} : 64'd0;
    end else begin
      pos_lim = is_signed ? {34'd0, {31{1'b1}}}
                          : {33'd0, {32{1'b1}}};
      neg_lim = is_signed ? {34'd1, 31'd0} : 65'd0;
      sat_pos = is_signed ? {33'd0, {31{1'b1}}}
                          : {64{1'b1}};
      sat_neg = is_signed ? {{33{1'b1}}, 31'd0}
                          : 64'd0;
    end
    overflow = sign ? (mag > neg_lim)
                    : (mag > pos_lim);
    twos = sign ? (64'd0 - mag[63:0]) : mag[63:0];
    flag_invalid = is_nan | is_ovf | overflow;
    flag_inexact = (guard | sticky) & ~flag_invalid;
    if (is_nan)
      result = sat_pos;
    else if (flag_invalid)
      result = sign ? sat_neg : sat_pos;
    else if (is_64bit)
      result = twos;
    else
      result = {{32{twos[31]}}, twos[31:0]};
  end

endmodule

// File: rtl/fp_to_int_converter.sv
// Multi-cycle FP->int converter: classify,
// align 8 bits/cycle, then round and saturate.
module fp_to_int_converter
  import fpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fp_to_int_converter_if.slave io
);

  cvt_state_e   state_q;
  cvt_state_e   state_d;

  logic [115:0] acc_q;
  logic [6:0]   rem_q;
  logic         sign_q;
  logic         nan_q;
  logic         ovf_q;
  logic         signed_q;
  logic         w64_q;
  logic [2:0]   rm_q;
  logic [63:0]  res_q;
  logic         inv_q;
  logic         inx_q;

  logic         dp;
  logic         sign_f;
  logic [10:0]  exp_f;
  logic [51:0]  frac_f;
  logic         exp_all1;
  logic [12:0]  exp_adj;
  logic [12:0]  e_unb;
  logic         e_neg;
  logic         e_ge64;
  logic [115:0] acc_init;
  logic [6:0]   rem_init;
  logic         go_shift;
  logic         cls_nan;
  logic         cls_ovf;
  logic [3:0]   shamt;

  logic [63:0]  rs_result;
  logic         rs_invalid;
  logic         rs_inexact;

  assign io.in_ready     = (state_q == CVT_IDLE);
  assign io.out_valid    = (state_q == CVT_DONE);
  assign io.result       = res_q;
  assign io.flag_invalid = inv_q;
  assign io.flag_inexact = inx_q;

  assign shamt = (rem_q > 7'd8) ? 4'd8 : rem_q[3:0];

  // Unpack operand and compute unbiased exponent
  always_comb begin
    dp     = io.is_double_precision;
    sign_f = dp ? io.operand[63] : io.operand[31];
    exp_f  = dp ? io.operand[62:52]
                : {3'b000, io.operand[30:23]};
    frac_f = dp ? io.operand[51:0]
                : {io.operand[22:0], 29'd0};
    exp_all1 = dp ? (&exp_f) : (&exp_f[7:0]);
    exp_adj  = (exp_f == 11'd0) ? 13'd1
                                : {2'b00, exp_f};
    e_unb  = exp_adj - (dp ? BIAS_DP : BIAS_SP);
    e_neg  = e_unb[12];
    e_ge64 = ~e_neg & (e_unb[11:6] != 6'd0);
  end

  // Classify and build the initial accumulator
  always_comb begin
    acc_init = '0;
    rem_init = '0;
    go_shift = 1'b0;
    cls_nan  = 1'b0;
    cls_ovf  = 1'b0;
    if (exp_all1) begin
      cls_nan = (frac_f != 52'd0);
      cls_ovf = (frac_f == 52'd0);
    end else if (exp_f == 11'd0 && frac_f == 52'd0) begin
      acc_init = '0;
    end else if (e_neg) begin
      // magnitude 0; only guard/sticky survive
      acc_init[51] = (e_unb == 13'h1FFF);
      acc_init[50] = (e_unb == 13'h1FFF)
                     ? (|frac_f) : 1'b1;
    end else if (e_ge64) begin
      cls_ovf = 1'b1;
    end else begin
      acc_init = {64'd1, frac_f};
      rem_init = e_unb[6:0];
      go_shift = (e_unb[6:0] != 7'd0);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= CVT_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CVT_IDLE:
        if (io.in_valid)
          state_d = go_shift ? CVT_SHIFT : CVT_ROUND;
      CVT_SHIFT:
        if (rem_q <= 7'd8)
          state_d = CVT_ROUND;
      CVT_ROUND:
        state_d = CVT_DONE;
      CVT_DONE:
        if (io.out_ready)
          state_d = CVT_IDLE;
      default:
        state_d = CVT_IDLE;
    endcase
  end

  // Operand capture, alignment and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      nan_q    <= 1'b0;
      ovf_q    <= 1'b0;
      signed_q <= 1'b0;
      w64_q    <= 1'b0;
      rm_q     <= '0;
      res_q    <= '0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      unique case (state_q)
        CVT_IDLE: begin
          if (io.in_valid) begin
            acc_q    <= acc_init;
            rem_q    <= rem_init;
            sign_q   <= sign_f;
            nan_q    <= cls_nan;
            ovf_q    <= cls_ovf;
            signed_q <= io.is_signed;
            w64_q    <= io.is_64bit_result;
            rm_q     <= io.rounding_mode;
          end
        end
        CVT_SHIFT: begin
          acc_q <= acc_q << shamt;
          rem_q <= rem_q - {3'b000, shamt};
        end
        CVT_ROUND: begin
          res_q <= rs_result;
          inv_q <= rs_invalid;
          inx_q <= rs_inexact;
        end
        default: begin
        end
      endcase
    end
  end

  fp_int_round_sat u_round_sat (
    .int_part      (acc_q[115:52]),
    .guard         (acc_q[51]),
    .sticky        (|acc_q[50:0]),
    .sign          (sign_q),
    .is_nan        (nan_q),
    .is_ovf        (ovf_q),
    .is_signed     (signed_q),
    .is_64bit      (w64_q),
    .rounding_mode (rm_q),
    .result        (rs_result),
    .flag_invalid  (rs_invalid),
    .flag_inexact  (rs_inexact)
  );

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Directed and randomized bench for the FP->int
// converter against an arithmetic reference model.
module tb_fp_to_int_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_to_int_converter_if bus ();

  fp_to_int_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h",
             tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fit(
    input logic signed [127:0] x, input logic w64);
    return w64 ? x[63:0] : {{32{x[31]}}, x[31:0]};
  endfunction

  // Value = mant * 2^(e - fb); round by comparing the
  // discarded remainder to one half ulp.
  function automatic void ref_model(
    input  logic [63:0] op,
    input  logic dp, input logic sg, input logic w64,
    input  logic [2:0] rm,
    output logic [63:0] res,
    output logic inv, output logic inx,
    output int edges);
    logic s;
    int ef, fb, bias, maxe, e, sh, nb;
    logic [127:0] mant, ip, rem, half, mag;
    logic signed [127:0] v, hi, lo;
    logic above, tie, any, inc;
    nb = w64 ? 64 : 32;
    hi = sg ? (128'sd1 <<< (nb - 1)) - 128'sd1
            : (128'sd1 <<< nb) - 128'sd1;
    lo = sg ? -(128'sd1 <<< (nb - 1)) : 128'sd0;
    if (dp) begin
      s = op[63]; ef = {21'd0, op[62:52]};
      mant = {76'd0, op[51:0]};
      fb = 52; bias = 1023; maxe = 2047;
    end else begin
      s = op[31]; ef = {24'd0, op[30:23]};
      mant = {105'd0, op[22:0]};
      fb = 23; bias = 127; maxe = 255;
    end
    inv = 1'b0; inx = 1'b0; edges = 2; res = '0;
    if (ef == maxe) begin
      inv = 1'b1;
      res = (mant != 0 || !s) ? fit(hi, w64) : fit(lo, w64);
      return;
    end
    if (ef == 0) e = 1 - bias;
    else begin
      e = ef - bias;
      mant[fb] = 1'b1;
    end
    if (e >= 64) begin
      inv = 1'b1;
      res = s ? fit(lo, w64) : fit(hi, w64);
      return;
    end
    if (e > 0) edges = 2 + (e + 7) / 8;
    sh = fb - e;
    if (sh <= 0) begin
      ip = mant << (-sh); rem = '0; half = 128'd1;
    end else if (sh >= 100) begin
      ip = '0; rem = mant; half = 128'd1 << 99;
    end else begin
      ip = mant >> sh;
      rem = mant & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
    end
    any = (rem != 0);
    tie = (rem == half);
    above = (rem > half);
    case (rm)
      3'd0: inc = above | (tie & ip[0]);
      3'd2: inc = any & s;
      3'd3: inc = any & !s;
      3'd4: inc = above | tie;
      default: inc = 1'b0;
    endcase
    mag = ip + {127'd0, inc};
    v = s ? -$signed(mag) : $signed(mag);
    if (v > hi) begin
      inv = 1'b1; res = fit(hi, w64);
    end else if (v < lo) begin
      inv = 1'b1; res = fit(lo, w64);
    end else begin
      res = fit(v, w64); inx = any;
    end
  endfunction

  task automatic run(input logic [63:0] op,
                     input logic dp, input logic sg,
                     input logic w64,
                     input logic [2:0] rm, input int hold,
                     output logic [63:0] res,
                     output logic inv, output logic inx,
                     output int edges);
    bus.operand = op;
    bus.is_double_precision = dp;
    bus.is_signed = sg;
    bus.is_64bit_result = w64;
    bus.rounding_mode = rm;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 16) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("out_valid_rise", {63'd0, bus.out_valid}, 64'd1);
    res = bus.result;
    inv = bus.flag_invalid;
    inx = bus.flag_inexact;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", bus.result, res);
      chk("hold_invalid", {63'd0, bus.flag_invalid},
          {63'd0, inv});
      chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("back_idle", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic dir(input string tag,
                     input logic [63:0] op,
                     input logic dp, input logic sg,
                     input logic w64, input logic [2:0] rm,
                     input logic [63:0] xr,
                     input logic xi, input logic xx,
                     input int xe, input int hold);
    logic [63:0] r;
    logic i, x;
    int e;
    run(op, dp, sg, w64, rm, hold, r, i, x, e);
    chk({tag, "_result"}, r, xr);
    chk({tag, "_invalid"}, {63'd0, i}, {63'd0, xi});
    chk({tag, "_inexact"}, {63'd0, x}, {63'd0, xx});
    if (xe > 0)
      chk({tag, "_edges"}, 64'(e), 64'(xe));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] op, r, xr, rnd, frac;
    logic dp, sg, w64, i, x, xi, xx;
    logic [2:0] rm;
    int e, xe, k, ev, tz;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.operand = '0;
    bus.is_double_precision = 1'b0;
    bus.is_signed = 1'b0;
    bus.is_64bit_result = 1'b0;
    bus.rounding_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_invalid", {63'd0, bus.flag_invalid}, 64'd0);
    chk("rst_inexact", {63'd0, bus.flag_inexact}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    dir("p3_5_rne", 64'h400C000000000000, 1, 1, 1, 3'd0,
        64'd4, 0, 1, 3, 0);
    dir("p2_5_rne", 64'h4004000000000000, 1, 1, 1, 3'd0,
        64'd2, 0, 1, 3, 0);
    dir("p2_5_rtz", 64'h4004000000000000, 1, 1, 1, 3'd1,
        64'd2, 0, 1, 3, 0);
    dir("p2_5_rup", 64'h4004000000000000, 1, 1, 1, 3'd3,
        64'd3, 0, 1, 3, 0);
    dir("p2_5_rmm", 64'h4004000000000000, 1, 1, 1, 3'd4,
        64'd3, 0, 1, 3, 0);
    dir("m1_5_u32", 64'h00000000BFC00000, 0, 0, 0, 3'd1,
        64'd0, 1, 0, 0, 0);
    dir("m0_25_u32", 64'h00000000BE800000, 0, 0, 0, 3'd1,
        64'd0, 0, 1, 0, 0);
    dir("p2_63_s64", 64'h43E0000000000000, 1, 1, 1, 3'd0,
        64'h7FFFFFFFFFFFFFFF, 1, 0, 10, 0);
    dir("m2_63_s64", 64'hC3E0000000000000, 1, 1, 1, 3'd0,
        64'h8000000000000000, 0, 0, 10, 0);
    dir("nan_s32", 64'h7FF8000000000000, 1, 1, 0, 3'd0,
        64'h000000007FFFFFFF, 1, 0, 2, 0);
    dir("minf_u64", 64'hFFF0000000000000, 1, 0, 1, 3'd0,
        64'd0, 1, 0, 2, 0);
    dir("hold", 64'h400C000000000000, 1, 1, 1, 3'd0,
        64'd4, 0, 1, 3, 5);

    // abort mid-alignment
    bus.operand = 64'h43E0000000000000;
    bus.is_double_precision = 1'b1;
    bus.is_signed = 1'b1;
    bus.is_64bit_result = 1'b1;
    bus.rounding_mode = 3'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("shift_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("abort_invalid", {63'd0, bus.flag_invalid}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_abort_ov", {63'd0, bus.out_valid}, 64'd0);
    dir("post_abort", 64'h400C000000000000, 1, 1, 1, 3'd0,
        64'd4, 0, 1, 3, 0);

    for (int n = 0; n < 400; n++) begin
      dp = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      w64 = 1'($urandom_range(0, 1));
      rm = 3'($urandom_range(0, 7));
      rnd = {$urandom, $urandom};
      frac = {12'd0, rnd[51:0]};
      if ($urandom_range(0, 1) == 1) begin
        tz = $urandom_range(0, 52);
        frac = (frac >> tz) << tz;
      end
      k = $urandom_range(0, 19);
      ev = $urandom_range(0, 72) - 4;
      rnd = {$urandom, $urandom};
      if (k == 0 && $urandom_range(0, 1) == 1)
        frac = '0;
      if (dp) begin
        op = {rnd[63], 11'(ev + 1023), frac[51:0]};
        if (k == 0) op[62:52] = '1;
        if (k == 1) op[62:52] = '0;
      end else begin
        op = {rnd[31:0], rnd[63], 8'(ev + 127),
              frac[51:29]};
        if (k == 0) op[30:23] = '1;
        if (k == 1) op[30:23] = '0;
      end
      ref_model(op, dp, sg, w64, rm, xr, xi, xx, xe);
      run(op, dp, sg, w64, rm, 0, r, i, x, e);
      chk("rnd_result", r, xr);
      chk("rnd_invalid", {63'd0, i}, {63'd0, xi});
      chk("rnd_inexact", {63'd0, x}, {63'd0, xx});
      chk("rnd_edges", 64'(e), 64'(xe));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
